// File: rtl/fetch_queue_unit.sv
// Fetch queue: issues sequential word fetches to a variable-latency, in-order
// instruction memory, buffers the returned words in a QDEPTH-entry queue and
// presents them to decode over valid/ready. A redirect flushes the queue and
// arranges for the wrong-path responses still in flight to be discarded.

// One queue slot: PC captured at allocation, instruction captured at fill.
module fetch_queue_entry #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill,
  input  logic [XLEN-1:0]   fill_instr,
  input  logic              clear,
  output logic [ADDR_W-1:0] pc,
  output logic [XLEN-1:0]   instr,
  output logic              filled
);

  // Slot storage; a fresh allocation or a pop/flush leaves the slot unfilled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      instr  <= '0;
      filled <= 1'b0;
    end else begin
      if (alloc) pc <= alloc_pc;
      if (fill)  instr <= fill_instr;
      if (clear || alloc) filled <= 1'b0;
      else if (fill)      filled <= 1'b1;
    end
  end

endmodule

module fetch_queue_unit #(
  parameter int                XLEN     = 32,
  parameter int                ADDR_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_valid,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [ADDR_W-1:0]         imem_req_addr,
  input  logic                      imem_rsp_valid,
  input  logic [XLEN-1:0]           imem_rsp_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_instr,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [ADDR_W-1:0]         out_pc_plus1,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int IW = $clog2(QDEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] QD   = PW'(QDEPTH);
  localparam logic [PW:0]   QD_X = (PW+1)'(QDEPTH);

  typedef logic [PW-1:0] ptr_t;

  logic [ADDR_W-1:0] fetch_pc;
  ptr_t              alloc_ptr, fill_ptr, rd_ptr;
  logic [PW-1:0]     alloc_cnt, drop_cnt;

  logic [QDEPTH-1:0][ADDR_W-1:0] e_pc;
  logic [QDEPTH-1:0][XLEN-1:0]   e_instr;
  logic [QDEPTH-1:0]             e_filled, e_alloc, e_fill, e_clear;

  logic          issue, pop, fill_rsp, drop_rsp;
  logic [PW-1:0] unfilled;
  logic [PW:0]   in_flight, redir_total;
  logic [PW-1:0] redir_drop;
  logic [IW-1:0] alloc_idx, fill_idx, rd_idx;

  assign alloc_idx = alloc_ptr[IW-1:0];
  assign fill_idx  = fill_ptr[IW-1:0];
  assign rd_idx    = rd_ptr[IW-1:0];

  // Allocated-but-unfilled entries: wrap-bit pointer distance, 0..QDEPTH.
  assign unfilled  = alloc_ptr - fill_ptr;

  // Issue is throttled on both queue space and total responses still owed,
  // so a wrong-path backlog can never overrun the queue.
  assign in_flight      = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign imem_req_valid = reset & ~redirect_valid & (alloc_cnt < QD) & (in_flight < QD_X);
  assign imem_req_addr  = fetch_pc;
  assign issue          = imem_req_valid & imem_req_ready;

  // Responses first pay off the drop debt; a stray response with nothing
  // awaiting fill is ignored. Only slots allocated in earlier cycles can fill.
  assign drop_rsp = imem_rsp_valid & (drop_cnt != '0);
  assign fill_rsp = imem_rsp_valid & ~redirect_valid & (drop_cnt == '0) & (unfilled != '0);

  assign out_valid    = e_filled[rd_idx] & (alloc_cnt != '0) & ~redirect_valid;
  assign out_instr    = e_instr[rd_idx];
  assign out_pc       = e_pc[rd_idx];
  assign out_pc_plus1 = out_pc + ADDR_W'(1);
  assign pop          = out_valid & out_ready;
  assign q_count      = alloc_cnt;

  // On redirect every unfilled slot still owes a response that must be thrown
  // away; a response landing in the redirect cycle itself settles one of them.
  always_comb begin
    redir_total = {1'b0, drop_cnt} + {1'b0, unfilled};
    redir_drop  = redir_total[PW-1:0];
    if (imem_rsp_valid && redir_total != '0) redir_drop = redir_total[PW-1:0] - PW'(1);
  end

  for (genvar i = 0; i < QDEPTH; i++) begin : g_ent
    assign e_alloc[i] = issue    && (alloc_idx == IW'(i));
    assign e_fill[i]  = fill_rsp && (fill_idx  == IW'(i));
    assign e_clear[i] = redirect_valid || (pop && (rd_idx == IW'(i)));

    fetch_queue_entry #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_ent (
      .clk        (clk),
      .reset      (reset),
      .alloc      (e_alloc[i]),
      .alloc_pc   (fetch_pc),
      .fill       (e_fill[i]),
      .fill_instr (imem_rsp_data),
      .clear      (e_clear[i]),
      .pc         (e_pc[i]),
      .instr      (e_instr[i]),
      .filled     (e_filled[i])
    );
  end

  // Fetch PC, queue pointers and counters; redirect overrides all other events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      alloc_cnt <= '0;
      drop_cnt  <= '0;
    end else if (redirect_valid) begin
      fetch_pc  <= redirect_pc;
      alloc_ptr <= rd_ptr;
      fill_ptr  <= rd_ptr;
      alloc_cnt <= '0;
      drop_cnt  <= redir_drop;
    end else begin
      if (issue) begin
        fetch_pc  <= fetch_pc + ADDR_W'(1);
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (fill_rsp) fill_ptr <= fill_ptr + PW'(1);
      if (pop)      rd_ptr   <= rd_ptr + PW'(1);
      alloc_cnt <= alloc_cnt + PW'(issue) - PW'(pop);
      if (drop_rsp) drop_cnt <= drop_cnt - PW'(1);
    end
  end

  // Occupancy must always equal the allocate/read pointer distance.
  a_cnt: assert property (@(posedge clk) disable iff (!reset)
    alloc_cnt == PW'(alloc_ptr - rd_ptr));

  // Fill pointer never runs ahead of allocation nor behind the read pointer.
  a_order: assert property (@(posedge clk) disable iff (!reset)
    PW'(fill_ptr - rd_ptr) <= PW'(alloc_ptr - rd_ptr));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: an in-order variable-latency memory model plus
// an architectural PC-stream reference (next request PC, next decode PC).
module tb_fetch_queue_unit;
  localparam int QDEPTH = 4;
  localparam int CW     = $clog2(QDEPTH) + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic          out_valid, out_ready;
  logic [31:0]   redirect_pc, imem_req_addr, imem_rsp_data, out_instr, out_pc, out_pc_plus1;
  logic [CW-1:0] q_count;

  logic          wd_redirect_valid, wd_req_valid, wd_req_ready, wd_rsp_valid, wd_out_valid, wd_out_ready;
  logic [31:0]   wd_redirect_pc, wd_req_addr, wd_rsp_data, wd_out_instr, wd_out_pc, wd_out_pc_plus1;
  logic [CW-1:0] wd_q_count;

  fetch_queue_unit #(.XLEN(32), .ADDR_W(32), .QDEPTH(QDEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus1(out_pc_plus1), .q_count(q_count));

  // Second instance starting just below the top of the address space.
  fetch_queue_unit #(.XLEN(32), .ADDR_W(32), .QDEPTH(QDEPTH), .RESET_PC(32'hFFFF_FFFE)) dut_w (
    .clk(clk), .reset(reset), .redirect_valid(wd_redirect_valid), .redirect_pc(wd_redirect_pc),
    .imem_req_valid(wd_req_valid), .imem_req_ready(wd_req_ready), .imem_req_addr(wd_req_addr),
    .imem_rsp_valid(wd_rsp_valid), .imem_rsp_data(wd_rsp_data),
    .out_valid(wd_out_valid), .out_ready(wd_out_ready), .out_instr(wd_out_instr), .out_pc(wd_out_pc),
    .out_pc_plus1(wd_out_pc_plus1), .q_count(wd_q_count));

  int checks = 0;
  int errors = 0;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  int    cyc, last_due, lat;

  // Values sampled at the negedge of the current cycle.
  logic          s_rv, s_acc, s_pop, s_ov;
  logic [31:0]   s_addr, s_pc, s_instr, s_pc1;
  logic [CW-1:0] s_qc;
  logic          w_rv, w_ov;
  logic [31:0]   w_addr, w_pc, w_instr, w_pc1;

  // One clock: sample at negedge, advance the memory model, drive responses.
  task automatic tick();
    int due;
    @(negedge clk);
    s_rv = imem_req_valid; s_addr = imem_req_addr; s_ov = out_valid; s_pc = out_pc;
    s_instr = out_instr; s_pc1 = out_pc_plus1; s_qc = q_count;
    s_acc = imem_req_valid & imem_req_ready;
    s_pop = out_valid & out_ready;
    w_rv = wd_req_valid; w_addr = wd_req_addr; w_ov = wd_out_valid; w_pc = wd_out_pc;
    w_instr = wd_out_instr; w_pc1 = wd_out_pc_plus1;
    if (imem_rsp_valid && mem_q.size() > 0) mem_q.delete(0);
    if (s_acc) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      mem_q.push_back('{s_addr, due});
      last_due = due;
    end
    @(posedge clk); #1;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    end
    wd_rsp_valid = w_rv;
    wd_rsp_data  = mem_word(w_addr);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0; out_ready = 1'b0; lat = 1;
    mem_q.delete(); imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    wd_rsp_valid = 1'b0; wd_rsp_data = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1; cyc = 0; last_due = 0;
  endtask

  task automatic test_reset();
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b0; lat = 2;
    repeat (5) tick();
    checks++; if (q_count !== CW'(4)) begin errors++; $display("FAIL pre_reset_qcount got %0d exp 4", q_count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_out_valid got %b exp 1", out_valid); end
    #2; reset = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (q_count !== '0) begin errors++; $display("FAIL reset_qcount got %0d exp 0", q_count); end
    checks++; if (wd_out_valid !== 1'b0) begin errors++; $display("FAIL reset_w_out_valid got %b exp 0", wd_out_valid); end
    do_reset();
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++;
      $display("FAIL release_req got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_req_addr); end
    checks++; if (q_count !== '0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL release_state got qc=%0d ov=%b exp 0 0", q_count, out_valid); end
    checks++; if (wd_req_addr !== 32'hFFFF_FFFE) begin errors++;
      $display("FAIL release_w_addr got %h exp fffffffe", wd_req_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b1; lat = 1;
    for (int k = 0; k < 10; k++) begin
      logic [31:0] e;
      tick();
      e = 32'(k - 2);
      checks++; if (!s_acc || s_addr !== 32'(k)) begin errors++;
        $display("FAIL stream_req c%0d got acc=%b a=%h exp a=%h", k, s_acc, s_addr, 32'(k)); end
      checks++; if (s_qc !== CW'(k < 2 ? k : 2)) begin errors++;
        $display("FAIL stream_qcount c%0d got %0d exp %0d", k, s_qc, (k < 2 ? k : 2)); end
      checks++; if (s_ov !== (k >= 2)) begin errors++;
        $display("FAIL stream_out_valid c%0d got %b exp %b", k, s_ov, (k >= 2)); end
      if (k >= 2) begin
        checks++; if (s_pc !== e || s_instr !== mem_word(e) || s_pc1 !== e + 32'd1) begin errors++;
          $display("FAIL stream_out c%0d got pc=%h i=%h p1=%h exp pc=%h i=%h p1=%h",
                   k, s_pc, s_instr, s_pc1, e, mem_word(e), e + 32'd1); end
      end
    end
  endtask

  task automatic test_backpressure();
    int npop;
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b0; lat = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 4) begin
        checks++; if (!s_acc || s_addr !== 32'(k)) begin errors++;
          $display("FAIL bp_fill_req c%0d got acc=%b a=%h exp a=%h", k, s_acc, s_addr, 32'(k)); end
      end else begin
        checks++; if (s_rv !== 1'b0 || s_qc !== CW'(4) || s_ov !== 1'b1 || s_pc !== 32'h0) begin errors++;
          $display("FAIL bp_full c%0d got rv=%b qc=%0d ov=%b pc=%h exp 0 4 1 0", k, s_rv, s_qc, s_ov, s_pc); end
      end
    end
    out_ready = 1'b1;
    npop = 0;
    for (int k = 6; k < 12; k++) begin
      tick();
      if (k == 6) begin
        checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL bp_full_on_pop got rv=%b exp 0", s_rv); end
      end
      if (k == 7) begin
        checks++; if (!s_acc || s_addr !== 32'd4) begin errors++;
          $display("FAIL bp_resume got acc=%b a=%h exp a=4", s_acc, s_addr); end
      end
      if (k <= 9) begin
        checks++; if (!s_pop || s_pc !== 32'(npop) || s_instr !== mem_word(32'(npop))) begin errors++;
          $display("FAIL bp_pop c%0d got pop=%b pc=%h i=%h exp pc=%h", k, s_pop, s_pc, s_instr, 32'(npop)); end
        npop++;
      end
    end
  endtask

  // Redirect with three requests outstanding and none returning in that
  // cycle; needs latency 4 so that no response coincides with the redirect.
  task automatic test_redirect();
    int n;
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b1; lat = 4;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    checks++; if (s_ov !== 1'b0 || s_rv !== 1'b0 || s_qc !== CW'(3)) begin errors++;
      $display("FAIL redir_cycle got ov=%b rv=%b qc=%0d exp 0 0 3", s_ov, s_rv, s_qc); end
    n = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 0) begin
        checks++; if (!s_acc || s_addr !== 32'h40) begin errors++;
          $display("FAIL redir_first_req got acc=%b a=%h exp a=40", s_acc, s_addr); end
      end
      if (s_pop) begin
        checks++; if (s_pc !== 32'h40 + 32'(n) || s_instr !== mem_word(32'h40 + 32'(n))) begin errors++;
          $display("FAIL redir_pop got pc=%h i=%h exp pc=%h i=%h", s_pc, s_instr, 32'h40 + 32'(n), mem_word(32'h40 + 32'(n))); end
        n++;
      end
    end
    checks++; if (n < 4) begin errors++; $display("FAIL redir_pop_count got %0d exp >=4", n); end
  endtask

  // Redirect coinciding with a response and a poppable head with out_ready=1.
  task automatic test_redirect_collision();
    int n;
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b1; lat = 3;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    checks++; if (s_ov !== 1'b0 || s_pop !== 1'b0 || s_rv !== 1'b0 || s_qc !== CW'(4)) begin errors++;
      $display("FAIL coll_cycle got ov=%b pop=%b rv=%b qc=%0d exp 0 0 0 4", s_ov, s_pop, s_rv, s_qc); end
    n = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 0) begin
        checks++; if (!s_acc || s_addr !== 32'h80) begin errors++;
          $display("FAIL coll_first_req got acc=%b a=%h exp a=80", s_acc, s_addr); end
      end
      if (s_pop) begin
        checks++; if (s_pc !== 32'h80 + 32'(n) || s_instr !== mem_word(32'h80 + 32'(n))) begin errors++;
          $display("FAIL coll_pop got pc=%h i=%h exp pc=%h i=%h", s_pc, s_instr, 32'h80 + 32'(n), mem_word(32'h80 + 32'(n))); end
        n++;
      end
    end
    checks++; if (n < 4) begin errors++; $display("FAIL coll_pop_count got %0d exp >=4", n); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      logic [31:0] ea, ep;
      tick();
      ea = 32'hFFFF_FFFE + 32'(k);
      ep = 32'hFFFF_FFFE + 32'(k) - 32'd2;
      checks++; if (w_rv !== 1'b1 || w_addr !== ea) begin errors++;
        $display("FAIL wrap_req c%0d got v=%b a=%h exp a=%h", k, w_rv, w_addr, ea); end
      if (k >= 2) begin
        checks++; if (w_ov !== 1'b1 || w_pc !== ep || w_instr !== mem_word(ep) || w_pc1 !== ep + 32'd1) begin errors++;
          $display("FAIL wrap_out c%0d got ov=%b pc=%h i=%h p1=%h exp pc=%h p1=%h", k, w_ov, w_pc, w_instr, w_pc1, ep, ep + 32'd1); end
        if (w_pc == 32'hFFFF_FFFF) begin
          checks++; if (w_pc1 !== 32'h0) begin errors++; $display("FAIL wrap_plus1 got %h exp 0", w_pc1); end
        end
      end
    end
  endtask

  // Random traffic: the decode stream must be the architectural PC sequence
  // of the current path, with nothing skipped, repeated or invented.
  task automatic test_random();
    logic [31:0] exp_req, exp_pop;
    int n_acc, n_pop, p_rdy, p_out;
    logic rd, held;
    do_reset();
    exp_req = 32'h0; exp_pop = 32'h0; n_acc = 0; n_pop = 0; held = 1'b0;
    p_rdy = 3; p_out = 3;
    for (int i = 0; i < 3030; i++) begin
      if (i % 150 == 0) begin p_rdy = $urandom_range(0, 4); p_out = $urandom_range(0, 4); end
      if (i < 3000) begin
        imem_req_ready = ($urandom_range(0, 4) < p_rdy + 1);
        out_ready      = ($urandom_range(0, 4) < p_out);
        rd             = ($urandom_range(0, 24) == 0);
      end else begin
        imem_req_ready = 1'b0; out_ready = 1'b1; rd = 1'b0;
      end
      lat = $urandom_range(1, 4);
      redirect_valid = rd;
      redirect_pc = !rd ? 32'h0 : ($urandom_range(0, 1) == 1 ? 32'($urandom) : 32'hFFFF_FFFC + 32'($urandom_range(0, 3)));
      tick();
      checks++; if (mem_q.size() > QDEPTH) begin errors++;
        $display("FAIL rnd_outstanding got %0d exp <=%0d", mem_q.size(), QDEPTH); end
      if (rd) begin
        checks++; if (s_ov !== 1'b0 || s_rv !== 1'b0) begin errors++;
          $display("FAIL rnd_redir_cycle got ov=%b rv=%b exp 0 0", s_ov, s_rv); end
        exp_req = redirect_pc; exp_pop = redirect_pc; n_acc = 0; n_pop = 0; held = 1'b0;
      end else begin
        checks++; if (s_qc !== CW'(n_acc - n_pop)) begin errors++;
          $display("FAIL rnd_qcount got %0d exp %0d", s_qc, n_acc - n_pop); end
        if (held) begin
          checks++; if (s_ov !== 1'b1 || s_pc !== exp_pop) begin errors++;
            $display("FAIL rnd_hold got ov=%b pc=%h exp 1 %h", s_ov, s_pc, exp_pop); end
        end
        if (s_acc) begin
          checks++; if (s_addr !== exp_req) begin errors++;
            $display("FAIL rnd_req got %h exp %h", s_addr, exp_req); end
          exp_req++; n_acc++;
        end
        if (s_pop) begin
          checks++; if (n_pop >= n_acc || s_pc !== exp_pop || s_instr !== mem_word(exp_pop) || s_pc1 !== exp_pop + 32'd1) begin errors++;
            $display("FAIL rnd_pop got pc=%h i=%h p1=%h exp pc=%h i=%h p1=%h (acc %0d pop %0d)",
                     s_pc, s_instr, s_pc1, exp_pop, mem_word(exp_pop), exp_pop + 32'd1, n_acc, n_pop); end
          exp_pop++; n_pop++;
        end
        held = s_ov && !out_ready;
      end
    end
    redirect_valid = 1'b0;
    checks++; if (n_pop != n_acc) begin errors++;
      $display("FAIL rnd_drain got popped %0d exp %0d", n_pop, n_acc); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    wd_redirect_valid = 1'b0; wd_redirect_pc = '0; wd_req_ready = 1'b1; wd_out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collision();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
